// File: rtl/dr_select_ctrl.sv
// JTAG data-register scheduler: instruction latch, BYPASS/IDCODE registers,
// BSR strobe routing and the registered, enable-qualified TDO.
module dr_select_ctrl #(
   parameter int                     IR_WIDTH     = 4,
   parameter logic [31:0]            IDCODE_VALUE = 32'h1BEE_F0C3,
   parameter logic [IR_WIDTH-1:0]    OP_EXTEST    = 'h0,
   parameter logic [IR_WIDTH-1:0]    OP_SAMPLE    = 'h1,
   parameter logic [IR_WIDTH-1:0]    OP_IDCODE    = 'h2,
   parameter logic [IR_WIDTH-1:0]    OP_BYPASS    = 'hF
) (
   input  logic                TCK,
   input  logic                TRST,
   input  logic                tap_reset,
   input  logic                ir_update,
   input  logic [IR_WIDTH-1:0] ir_parallel,
   input  logic                ir_shift,
   input  logic                ir_tdo,
   input  logic                dr_capture,
   input  logic                dr_shift,
   input  logic                dr_update,
   input  logic                TDI,
   input  logic                bsr_tdo,
   output logic                bsr_select,
   output logic                bsr_mode,
   output logic                bsr_capture,
   output logic                bsr_shift,
   output logic                bsr_update,
   output logic [IR_WIDTH-1:0] active_instr,
   output logic [5:0]          shift_count,
   output logic                TDO,
   output logic                tdo_en
);

   logic [IR_WIDTH-1:0] instr_q, instr_d;
   logic                bypass_q, bypass_d;
   logic [31:0]         idcode_q, idcode_d;
   logic [5:0]          cnt_q, cnt_d;
   logic                tdo_q, tdo_d;
   logic                tdo_en_q, tdo_en_d;

   logic sel_bsr, sel_id, sel_byp;
   logic ir_legal;
   logic dr_so;

   always_comb begin
      sel_bsr  = (instr_q == OP_EXTEST) || (instr_q == OP_SAMPLE);
      sel_id   = (instr_q == OP_IDCODE);
      sel_byp  = !sel_bsr && !sel_id;
      ir_legal = (ir_parallel == OP_EXTEST) || (ir_parallel == OP_SAMPLE) ||
                 (ir_parallel == OP_IDCODE) || (ir_parallel == OP_BYPASS);
   end

   always_comb begin
      dr_so = bypass_q;
      unique case (1'b1)
         sel_bsr: dr_so = bsr_tdo;
         sel_id:  dr_so = idcode_q[0];
         default: dr_so = bypass_q;
      endcase
   end

   always_comb begin
      instr_d  = instr_q;
      bypass_d = bypass_q;
      idcode_d = idcode_q;
      cnt_d    = cnt_q;
      tdo_d    = 1'b0;
      tdo_en_d = 1'b0;
      if (tap_reset) begin
         instr_d  = OP_IDCODE;
         bypass_d = 1'b0;
         idcode_d = IDCODE_VALUE;
         cnt_d    = '0;
      end else begin
         // DR ops use the instruction in force before this edge's update
         if (dr_capture) begin
            if (sel_byp) bypass_d = 1'b0;
            if (sel_id)  idcode_d = IDCODE_VALUE;
            cnt_d = '0;
         end else if (dr_shift) begin
            if (sel_byp) bypass_d = TDI;
            if (sel_id)  idcode_d = {TDI, idcode_q[31:1]};
            if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
         end
         if (ir_shift) begin
            tdo_d    = ir_tdo;
            tdo_en_d = 1'b1;
         end else if (dr_shift) begin
            tdo_d    = dr_so;
            tdo_en_d = 1'b1;
         end
         if (ir_update) instr_d = ir_legal ? ir_parallel : OP_BYPASS;
      end
   end

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         instr_q  <= OP_IDCODE;
         bypass_q <= 1'b0;
         idcode_q <= IDCODE_VALUE;
         cnt_q    <= '0;
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         instr_q  <= instr_d;
         bypass_q <= bypass_d;
         idcode_q <= idcode_d;
         cnt_q    <= cnt_d;
         tdo_q    <= tdo_d;
         tdo_en_q <= tdo_en_d;
      end
   end

   assign bsr_select   = sel_bsr;
   assign bsr_mode     = (instr_q == OP_EXTEST);
   assign bsr_capture  = dr_capture & sel_bsr & ~tap_reset;
   assign bsr_shift    = dr_shift & sel_bsr & ~tap_reset;
   assign bsr_update   = dr_update & sel_bsr & ~tap_reset;
   assign active_instr = instr_q;
   assign shift_count  = cnt_q;
   assign TDO          = tdo_q;
   assign tdo_en       = tdo_en_q;

endmodule

// File: tb/tb_dr_select_ctrl.sv
// Scoreboard bench for dr_select_ctrl: directed JTAG sequences plus random
// strobes, checked against a bit-queue reference model.
module tb_dr_select_ctrl;

   localparam logic [31:0] IDV = 32'h1BEE_F0C3;

   logic       TCK, TRST, tap_reset, ir_update, ir_shift, ir_tdo;
   logic [3:0] ir_parallel;
   logic       dr_capture, dr_shift, dr_update, TDI, bsr_tdo;
   logic       bsr_select, bsr_mode, bsr_capture, bsr_shift, bsr_update;
   logic [3:0] active_instr;
   logic [5:0] shift_count;
   logic       TDO, tdo_en;

   dr_select_ctrl dut (
      .TCK(TCK), .TRST(TRST), .tap_reset(tap_reset),
      .ir_update(ir_update), .ir_parallel(ir_parallel),
      .ir_shift(ir_shift), .ir_tdo(ir_tdo),
      .dr_capture(dr_capture), .dr_shift(dr_shift),
      .dr_update(dr_update), .TDI(TDI), .bsr_tdo(bsr_tdo),
      .bsr_select(bsr_select), .bsr_mode(bsr_mode),
      .bsr_capture(bsr_capture), .bsr_shift(bsr_shift),
      .bsr_update(bsr_update), .active_instr(active_instr),
      .shift_count(shift_count), .TDO(TDO), .tdo_en(tdo_en)
   );

   typedef struct packed {
      logic [3:0] instr;
      logic [5:0] cnt;
      logic       tdo, en, sel, mode, cap, sh, upd;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;

   logic [3:0] m_instr;
   int         m_cnt;
   logic       m_tdo, m_en, m_byp;
   logic       m_id[$];

   initial begin
      TCK = 1'b0;
      forever #5 TCK = ~TCK;
   end

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
   endtask

   function automatic void m_load_id();
      m_id = {};
      for (int i = 0; i < 32; i++) m_id.push_back(IDV[i]);
   endfunction

   function automatic void m_reset();
      m_instr = 4'h2;
      m_cnt   = 0;
      m_tdo   = 1'b0;
      m_en    = 1'b0;
      m_byp   = 1'b0;
      m_load_id();
   endfunction

   task automatic cyc(input logic tr, tres, iu, input logic [3:0] ip,
                      input logic is, it, dc, ds, du, ti, bt);
      logic bsr, id, so;
      exp_t e;
      @(negedge TCK);
      TRST = tr; tap_reset = tres; ir_update = iu; ir_parallel = ip;
      ir_shift = is; ir_tdo = it; dr_capture = dc; dr_shift = ds;
      dr_update = du; TDI = ti; bsr_tdo = bt;
      if (tr || tres) m_reset();
      else begin
         bsr = (m_instr == 4'h0) || (m_instr == 4'h1);
         id  = (m_instr == 4'h2);
         so  = bsr ? bt : (id ? m_id[0] : m_byp);
         if (dc) begin
            if (id) m_load_id();
            else if (!bsr) m_byp = 1'b0;
            m_cnt = 0;
         end else if (ds) begin
            if (id) begin
               void'(m_id.pop_front());
               m_id.push_back(ti);
            end else if (!bsr) m_byp = ti;
            m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
         end
         if (is) begin m_tdo = it; m_en = 1'b1; end
         else if (ds) begin m_tdo = so; m_en = 1'b1; end
         else begin m_tdo = 1'b0; m_en = 1'b0; end
         if (iu) m_instr = (ip inside {4'h0, 4'h1, 4'h2, 4'hF}) ? ip : 4'hF;
      end
      e.instr = m_instr;
      e.cnt   = 6'(m_cnt);
      e.tdo   = m_tdo;
      e.en    = m_en;
      e.sel   = (m_instr == 4'h0) || (m_instr == 4'h1);
      e.mode  = (m_instr == 4'h0);
      e.cap   = dc & e.sel & ~tres;
      e.sh    = ds & e.sel & ~tres;
      e.upd   = du & e.sel & ~tres;
      sb.push_back(e);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic upd_ir(input logic [3:0] ip);
      cyc(0, 0, 1, ip, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic capture();
      cyc(0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0);
   endtask
   task automatic shift(input logic ti, input logic bt);
      cyc(0, 0, 0, 4'h0, 0, 0, 0, 1, 0, ti, bt);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge TCK);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("active_instr", 32'(active_instr), 32'(e.instr));
            chk("shift_count", 32'(shift_count), 32'(e.cnt));
            chk("TDO", 32'(TDO), 32'(e.tdo));
            chk("tdo_en", 32'(tdo_en), 32'(e.en));
            chk("bsr_select", 32'(bsr_select), 32'(e.sel));
            chk("bsr_mode", 32'(bsr_mode), 32'(e.mode));
            chk("bsr_capture", 32'(bsr_capture), 32'(e.cap));
            chk("bsr_shift", 32'(bsr_shift), 32'(e.sh));
            chk("bsr_update", 32'(bsr_update), 32'(e.upd));
         end
      end
   end

   initial begin : stim
      logic is, ds, dc;
      TRST = 1'b1; tap_reset = 0; ir_update = 0; ir_parallel = 0;
      ir_shift = 0; ir_tdo = 0; dr_capture = 0; dr_shift = 0;
      dr_update = 0; TDI = 0; bsr_tdo = 0;
      m_reset();
      repeat (2) cyc(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
      idle();

      capture();
      for (int i = 0; i < 32; i++) shift(0, 0);
      idle();

      // async TRST in the middle of an IDCODE shift
      capture();
      for (int i = 0; i < 5; i++) shift(1, 0);
      @(posedge TCK);
      #3 TRST = 1'b1;
      #1;
      chk("trst_TDO", 32'(TDO), 32'h0);
      chk("trst_tdo_en", 32'(tdo_en), 32'h0);
      chk("trst_instr", 32'(active_instr), 32'h2);
      cyc(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      capture();
      for (int i = 0; i < 32; i++) shift(0, 0);
      idle();

      upd_ir(4'hF);
      capture();
      shift(1, 0); shift(0, 0); shift(1, 0);
      idle();

      upd_ir(4'h0);
      shift(0, 1); shift(1, 0);
      cyc(0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 0);
      upd_ir(4'h1);
      capture(); shift(0, 1);
      upd_ir(4'h7);
      idle();

      cyc(0, 1, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0);
      capture();
      for (int i = 0; i < 70; i++) shift(1, 0);
      idle();

      for (int k = 0; k < 3000; k++) begin
         dc = ($urandom_range(0, 7) == 0);
         ds = !dc && ($urandom_range(0, 1) == 1);
         is = !ds && ($urandom_range(0, 5) == 0);
         cyc(0, ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
             4'($urandom), is, 1'($urandom), dc, ds,
             ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom));
      end
      idle();
      repeat (3) @(posedge TCK);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
